// File: rtl/cva6_clic_irq_bridge_pkg.sv
// Shared types for the CLIC interrupt bridge and the CLIC accept controller.
// priv_lvl_t mirrors the riscv privilege encoding so both ends agree on it.
package cva6_clic_irq_bridge_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    localparam int unsigned CLICNumInterruptSrc = 256;
    localparam int unsigned ClicIdWidth         = $clog2(CLICNumInterruptSrc);

    typedef struct packed {
        logic [ClicIdWidth-1:0] id;
        logic [7:0]             level;
        priv_lvl_t              priv;
        logic                   shv;
    } clic_irq_t;

endpackage

// File: rtl/cva6_clic_irq_bridge_if.sv
// CLIC-side request/withdraw handshake plus the core-side registered request.
// slave is the bridge's view; master is the view of whoever drives the CLIC side.
interface cva6_clic_irq_bridge_if #(
    parameter int unsigned NumSrc = 256
) ();
    import cva6_clic_irq_bridge_pkg::*;

    localparam int unsigned IdWidth = $clog2(NumSrc);

    logic               clic_irq_valid_i;
    logic [IdWidth-1:0] clic_irq_id_i;
    logic [7:0]         clic_irq_level_i;
    priv_lvl_t          clic_irq_priv_i;
    logic               clic_irq_shv_i;
    logic               clic_irq_ready_o;
    logic               clic_kill_req_i;
    logic               clic_kill_ack_o;

    logic               irq_valid_o;
    logic [IdWidth-1:0] irq_id_o;
    logic [7:0]         irq_level_o;
    priv_lvl_t          irq_priv_o;
    logic               irq_shv_o;
    logic               irq_taken_i;

    modport slave (
        input  clic_irq_valid_i, clic_irq_id_i, clic_irq_level_i, clic_irq_priv_i,
               clic_irq_shv_i, clic_kill_req_i, irq_taken_i,
        output clic_irq_ready_o, clic_kill_ack_o,
               irq_valid_o, irq_id_o, irq_level_o, irq_priv_o, irq_shv_o
    );

    modport master (
        output clic_irq_valid_i, clic_irq_id_i, clic_irq_level_i, clic_irq_priv_i,
               clic_irq_shv_i, clic_kill_req_i, irq_taken_i,
        input  clic_irq_ready_o, clic_kill_ack_o,
               irq_valid_o, irq_id_o, irq_level_o, irq_priv_o, irq_shv_o
    );

endinterface

// File: rtl/cva6_clic_irq_bridge.sv
// Holds one CLIC interrupt request for the core until it is taken or withdrawn.
// Every output is a flop; pulses are registered from the next-state decode.
module cva6_clic_irq_bridge
    import cva6_clic_irq_bridge_pkg::*;
#(
    parameter int unsigned NumSrc = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    cva6_clic_irq_bridge_if.slave         bus
);

    localparam int unsigned IdWidth = $clog2(NumSrc);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        READY,
        KILL
    } state_t;

    state_t             state_q, state_d;
    logic               kill_seen_q, kill_seen_d;
    logic               capture;

    logic               valid_q;
    logic               ready_q;
    logic               ack_q;
    logic [IdWidth-1:0] id_q;
    logic [7:0]         level_q;
    priv_lvl_t          priv_q;
    logic               shv_q;

    always_comb begin
        state_d     = state_q;
        kill_seen_d = kill_seen_q;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // After a withdrawal, wait for kill_req to drop before accepting anything.
                if (kill_seen_q) begin
                    kill_seen_d = bus.clic_kill_req_i;
                end else if (bus.clic_kill_req_i) begin
                    state_d = KILL;
                end else if (bus.clic_irq_valid_i) begin
                    capture = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (bus.irq_taken_i) begin
                    state_d = READY;
                end else if (bus.clic_kill_req_i) begin
                    state_d = KILL;
                end
            end
            READY: begin
                state_d = bus.clic_kill_req_i ? KILL : IDLE;
            end
            KILL: begin
                kill_seen_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            kill_seen_q <= 1'b0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            id_q        <= '0;
            level_q     <= '0;
            priv_q      <= PRIV_LVL_M;
            shv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_seen_q <= kill_seen_d;
            valid_q     <= (state_d == HELD);
            ready_q     <= (state_d == READY);
            ack_q       <= (state_d == KILL);
            if (capture) begin
                id_q    <= bus.clic_irq_id_i;
                level_q <= bus.clic_irq_level_i;
                priv_q  <= bus.clic_irq_priv_i;
                shv_q   <= bus.clic_irq_shv_i;
            end
        end
    end

    assign bus.irq_valid_o      = valid_q;
    assign bus.irq_id_o         = id_q;
    assign bus.irq_level_o      = level_q;
    assign bus.irq_priv_o       = priv_q;
    assign bus.irq_shv_o        = shv_q;
    assign bus.clic_irq_ready_o = ready_q;
    assign bus.clic_kill_ack_o  = ack_q;

endmodule

// File: tb/tb_cva6_clic_irq_bridge.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a transaction-level reference model of the bridge.
module tb_cva6_clic_irq_bridge;
    import cva6_clic_irq_bridge_pkg::*;

    logic clk;
    logic rst_n;

    cva6_clic_irq_bridge_if #(.NumSrc(256)) bus ();

    cva6_clic_irq_bridge #(.NumSrc(256)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cycle    = 0;

    // Reference model: what the core and CLIC should currently see.
    bit        m_valid, m_ready, m_ack, m_blocked;
    logic [7:0] m_id, m_level;
    priv_lvl_t m_priv;
    bit        m_shv;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_ready = 0; m_ack = 0; m_blocked = 0;
        m_id = '0; m_level = '0; m_priv = PRIV_LVL_M; m_shv = 0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        bit was_valid, was_ready, was_ack;
        was_valid = m_valid; was_ready = m_ready; was_ack = m_ack;
        m_ready = 0;
        m_ack   = 0;
        if (was_valid) begin
            if (bus.irq_taken_i) begin
                m_valid = 0; m_ready = 1;
            end else if (bus.clic_kill_req_i) begin
                m_valid = 0; m_ack = 1;
            end
        end else if (was_ready) begin
            if (bus.clic_kill_req_i) m_ack = 1;
        end else if (was_ack) begin
            m_blocked = 1;
        end else if (m_blocked) begin
            m_blocked = bus.clic_kill_req_i;
        end else if (bus.clic_kill_req_i) begin
            m_ack = 1;
        end else if (bus.clic_irq_valid_i) begin
            m_valid = 1;
            m_id    = bus.clic_irq_id_i;
            m_level = bus.clic_irq_level_i;
            m_priv  = bus.clic_irq_priv_i;
            m_shv   = bus.clic_irq_shv_i;
        end
    endtask

    task automatic check_all();
        check_eq("irq_valid", 32'(bus.irq_valid_o), 32'(m_valid));
        check_eq("irq_id",    32'(bus.irq_id_o),    32'(m_id));
        check_eq("irq_level", 32'(bus.irq_level_o), 32'(m_level));
        check_eq("irq_priv",  32'(bus.irq_priv_o),  32'(m_priv));
        check_eq("irq_shv",   32'(bus.irq_shv_o),   32'(m_shv));
        check_eq("ready",     32'(bus.clic_irq_ready_o), 32'(m_ready));
        check_eq("kill_ack",  32'(bus.clic_kill_ack_o),  32'(m_ack));
        check_eq("ready_ack_excl", 32'(bus.clic_irq_ready_o & bus.clic_kill_ack_o), 32'd0);
    endtask

    // Inputs are driven between negedge and posedge; outputs checked on negedge.
    task automatic step();
        @(posedge clk);
        cycle++;
        if (rst_n) model_edge(); else model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit v, input logic [7:0] id, input logic [7:0] lvl,
                         input priv_lvl_t pr, input bit shv, input bit kill, input bit taken);
        bus.clic_irq_valid_i = v;
        bus.clic_irq_id_i    = id;
        bus.clic_irq_level_i = lvl;
        bus.clic_irq_priv_i  = pr;
        bus.clic_irq_shv_i   = shv;
        bus.clic_kill_req_i  = kill;
        bus.irq_taken_i      = taken;
    endtask

    function automatic priv_lvl_t rand_priv();
        case ($urandom_range(0, 2))
            0:       return PRIV_LVL_U;
            1:       return PRIV_LVL_S;
            default: return PRIV_LVL_M;
        endcase
    endfunction

    initial begin
        int last_ready;
        rst_n = 1'b0;
        drive(0, 8'd0, 8'd0, PRIV_LVL_U, 0, 0, 0);
        model_reset();
        @(negedge clk);
        check_all();
        step();
        rst_n = 1'b1;
        step();

        // Basic request, taken three cycles after it was raised.
        drive(1, 8'd5, 8'h80, PRIV_LVL_M, 0, 0, 0);
        step();
        check_eq("basic_valid_c1", 32'(bus.irq_valid_o), 32'd1);
        check_eq("basic_id_c1",    32'(bus.irq_id_o),    32'd5);
        check_eq("basic_level_c1", 32'(bus.irq_level_o), 32'h80);
        drive(0, 8'd0, 8'd0, PRIV_LVL_U, 0, 0, 0);
        step();
        bus.irq_taken_i = 1;
        step();
        bus.irq_taken_i = 0;
        check_eq("basic_ready_c4", 32'(bus.clic_irq_ready_o), 32'd1);
        check_eq("basic_valid_c4", 32'(bus.irq_valid_o),      32'd0);
        step();
        step();

        // Withdrawal of a held request.
        drive(1, 8'd7, 8'h10, PRIV_LVL_S, 1, 0, 0);
        step();
        drive(0, 8'd0, 8'd0, PRIV_LVL_U, 0, 0, 0);
        step();
        bus.clic_kill_req_i = 1;
        step();
        bus.clic_kill_req_i = 0;
        check_eq("kill_ack",       32'(bus.clic_kill_ack_o),  32'd1);
        check_eq("kill_valid_low", 32'(bus.irq_valid_o),      32'd0);
        check_eq("kill_no_ready",  32'(bus.clic_irq_ready_o), 32'd0);
        repeat (3) step();

        // Take and kill in the same held cycle: ready first, ack after.
        drive(1, 8'd3, 8'h22, PRIV_LVL_M, 0, 0, 0);
        step();
        drive(0, 8'd0, 8'd0, PRIV_LVL_U, 0, 1, 1);
        step();
        check_eq("simul_ready_n1", 32'(bus.clic_irq_ready_o), 32'd1);
        bus.irq_taken_i = 0;
        step();
        bus.clic_kill_req_i = 0;
        check_eq("simul_ack_n2",   32'(bus.clic_kill_ack_o),  32'd1);
        repeat (3) step();

        // Input churn while held.
        drive(1, 8'd5, 8'h44, PRIV_LVL_U, 1, 0, 0);
        step();
        bus.clic_irq_id_i = 8'd9;
        repeat (3) step();
        check_eq("churn_id_held", 32'(bus.irq_id_o), 32'd5);

        // Asynchronous reset while held, valid still asserted afterwards.
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_eq("areset_valid", 32'(bus.irq_valid_o), 32'd0);
        check_eq("areset_id",    32'(bus.irq_id_o),    32'd0);
        check_eq("areset_priv",  32'(bus.irq_priv_o),  32'(PRIV_LVL_M));
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step();
        check_eq("post_reset_recapture", 32'(bus.irq_valid_o), 32'd1);
        bus.irq_taken_i = 1;
        step();
        step();

        // Back-to-back takes: ready pulses exactly three cycles apart.
        drive(1, 8'd11, 8'h01, PRIV_LVL_M, 0, 0, 1);
        last_ready = -1;
        for (int unsigned i = 0; i < 12; i++) begin
            step();
            if (bus.clic_irq_ready_o) begin
                if (last_ready >= 0) check_eq("b2b_spacing", 32'(int'(cycle) - last_ready), 32'd3);
                last_ready = int'(cycle);
            end
        end
        drive(0, 8'd0, 8'd0, PRIV_LVL_U, 0, 0, 0);
        repeat (3) step();

        // Random traffic with occasional mid-cycle resets.
        for (int unsigned i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 99) < 70, 8'($urandom), 8'($urandom), rand_priv(),
                  1'($urandom), $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 40);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                check_all();
            end else if (!rst_n && $urandom_range(0, 1) == 1) begin
                rst_n = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
